// File: rtl/inst_trace_monitor.sv
// Purpose : instruction-retire monitor; per-class saturating counters plus a PC/instruction trace FIFO.
// Latency : counters and FIFO update on the retire edge; cnt_val is registered (shows pre-update counts).
// Backpr. : host drains through rd_valid/rd_ready; when full, new entries are dropped or the oldest is overwritten.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   ret_valid/ret_inst/ret_pc    retired-instruction sample from the datapath
//   trig_en                      trace capture enable (counters always count)
//   clr                          synchronous clear of counters, FIFO and overflow
//   cnt_sel -> cnt_val           counter read port: 0-10 classes, 11 total, 12-15 zero
//   rd_valid/rd_ready/rd_pc/rd_inst/rd_class   show-ahead trace FIFO head
//   fifo_count, overflow         occupancy and sticky lost-entry flag
module inst_trace_monitor #(
    parameter int PC_W      = 32,
    parameter int DEPTH     = 16,
    parameter int COUNT_W   = 32,
    parameter int OVERWRITE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ret_valid,
    input  logic [31:0]              ret_inst,
    input  logic [PC_W-1:0]          ret_pc,
    input  logic                     trig_en,
    input  logic                     clr,
    input  logic [3:0]               cnt_sel,
    output logic [COUNT_W-1:0]       cnt_val,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [PC_W-1:0]          rd_pc,
    output logic [31:0]              rd_inst,
    output logic [3:0]               rd_class,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);
    localparam int AW   = $clog2(DEPTH);
    localparam int NCNT = 12;          // 11 classes + total
    localparam int EW   = PC_W + 32 + 4;
    localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
    localparam logic [AW-1:0]      PTR_ONE  = AW'(1);
    localparam logic [AW:0]        CNT1     = (AW+1)'(1);
    localparam logic [AW:0]        FULL_CNT = (AW+1)'(DEPTH);

    // ---------------- class decode ----------------
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] cls;

    assign op = ret_inst[31:26];
    assign fn = ret_inst[5:0];

    always_comb begin
        cls = 4'd10;
        case (op)
            6'b100011: cls = 4'd0;
            6'b101011: cls = 4'd1;
            6'b000100: cls = 4'd2;
            6'b000101: cls = 4'd3;
            6'b000010: cls = 4'd4;
            6'b000000: begin
                case (fn)
                    6'b100000: cls = 4'd5;
                    6'b100010: cls = 4'd6;
                    6'b100100: cls = 4'd7;
                    6'b100101: cls = 4'd8;
                    6'b101010: cls = 4'd9;
                    default:   cls = 4'd10;
                endcase
            end
            default: cls = 4'd10;
        endcase
    end

    // ---------------- counters ----------------
    logic [COUNT_W-1:0] cnt_q [NCNT];
    logic [COUNT_W-1:0] cnt_d [NCNT];
    logic [COUNT_W-1:0] cnt_val_q;
    logic [COUNT_W-1:0] cnt_val_d;

    always_comb begin
        for (int i = 0; i < NCNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = '0;
            end else if (ret_valid && (i == int'(cls) || i == NCNT - 1) && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Read mux samples the current (pre-update) counter state.
    always_comb begin
        cnt_val_d = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (cnt_sel == 4'(i)) cnt_val_d = cnt_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
            cnt_val_q <= '0;
        end else begin
            for (int i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
            cnt_val_q <= cnt_val_d;
        end
    end

    assign cnt_val = cnt_val_q;

    // ---------------- trace FIFO ----------------
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, pop, full, wr_en;

    assign push     = ret_valid & trig_en;
    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid & rd_ready;
    assign full     = (count_q == FULL_CNT);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                if (!full || pop) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                end else begin
                    overflow_d = 1'b1;
                    if (OVERWRITE != 0) begin
                        // Full means wr_ptr == rd_ptr: the write lands on the
                        // oldest entry, so the head simply moves past it.
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                    end
                end
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop && !full) begin
                count_d = count_q + CNT1;
            end else if (pop && !push) begin
                count_d = count_q - CNT1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: outputs are gated by rd_valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {ret_pc, ret_inst, cls};
    end

    logic [EW-1:0] head;
    assign head       = mem_q[rd_ptr_q];
    assign rd_pc      = rd_valid ? head[EW-1 -: PC_W] : '0;
    assign rd_inst    = rd_valid ? head[35:4]         : '0;
    assign rd_class   = rd_valid ? head[3:0]          : '0;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_inst_trace_monitor.sv
// Purpose : self-checking bench for inst_trace_monitor (DEPTH=4, COUNT_W=4; drop and overwrite variants).
// Latency : model advances once per clock; outputs sampled 1 time unit after the rising edge.
// Backpr. : rd_ready driven by the bench; queue model pops on accepted heads.
module tb_inst_trace_monitor;
    localparam int D   = 4;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          ret_valid;
    logic [31:0]   ret_inst;
    logic [31:0]   ret_pc;
    logic          trig_en;
    logic          clr;
    logic [3:0]    cnt_sel;
    logic          rd_ready;

    logic [CW-1:0] cnt_val_a, cnt_val_b;
    logic          rd_valid_a, rd_valid_b;
    logic [31:0]   rd_pc_a, rd_pc_b, rd_inst_a, rd_inst_b;
    logic [3:0]    rd_class_a, rd_class_b;
    logic [2:0]    fifo_count_a, fifo_count_b;
    logic          overflow_a, overflow_b;

    always #5 clk = ~clk;

    inst_trace_monitor #(.PC_W(32), .DEPTH(D), .COUNT_W(CW), .OVERWRITE(0)) u_drop (
        .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_inst(ret_inst), .ret_pc(ret_pc),
        .trig_en(trig_en), .clr(clr), .cnt_sel(cnt_sel), .cnt_val(cnt_val_a),
        .rd_valid(rd_valid_a), .rd_ready(rd_ready), .rd_pc(rd_pc_a), .rd_inst(rd_inst_a),
        .rd_class(rd_class_a), .fifo_count(fifo_count_a), .overflow(overflow_a)
    );

    inst_trace_monitor #(.PC_W(32), .DEPTH(D), .COUNT_W(CW), .OVERWRITE(1)) u_ovw (
        .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_inst(ret_inst), .ret_pc(ret_pc),
        .trig_en(trig_en), .clr(clr), .cnt_sel(cnt_sel), .cnt_val(cnt_val_b),
        .rd_valid(rd_valid_b), .rd_ready(rd_ready), .rd_pc(rd_pc_b), .rd_inst(rd_inst_b),
        .rd_class(rd_class_b), .fifo_count(fifo_count_b), .overflow(overflow_b)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [3:0]  cls;
    } ent_t;

    ent_t       q0[$];
    ent_t       q1[$];
    logic       exp_ovf0, exp_ovf1;
    int         exp_cnt[12];
    logic [3:0] cur_cls;
    int         checks = 0;
    int         errors = 0;

    // One clock of the reference model, then advance the DUT.
    task automatic tick();
        bit   push, pop0, pop1, full0, full1;
        ent_t e;
        push  = ret_valid && trig_en;
        pop0  = rd_ready && (q0.size() != 0);
        pop1  = rd_ready && (q1.size() != 0);
        full0 = (q0.size() == D);
        full1 = (q1.size() == D);
        e     = '{pc: ret_pc, inst: ret_inst, cls: cur_cls};
        if (clr) begin
            q0.delete();
            q1.delete();
            exp_ovf0 = 1'b0;
            exp_ovf1 = 1'b0;
            for (int i = 0; i < 12; i++) exp_cnt[i] = 0;
        end else begin
            if (ret_valid) begin
                if (exp_cnt[cur_cls] < SAT) exp_cnt[cur_cls]++;
                if (exp_cnt[11] < SAT) exp_cnt[11]++;
            end
            if (pop0) void'(q0.pop_front());
            if (pop1) void'(q1.pop_front());
            if (push) begin
                if (!full0 || pop0) q0.push_back(e);
                else exp_ovf0 = 1'b1;
                if (!full1 || pop1) q1.push_back(e);
                else begin
                    void'(q1.pop_front());
                    q1.push_back(e);
                    exp_ovf1 = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] inst, input logic [31:0] pc, input logic [3:0] cls);
        ret_valid = 1'b1;
        ret_inst  = inst;
        ret_pc    = pc;
        cur_cls   = cls;
        tick();
        ret_valid = 1'b0;
    endtask

    task automatic read_cnt(input logic [3:0] sel, output logic [CW-1:0] va, output logic [CW-1:0] vb);
        cnt_sel = sel;
        tick();
        va = cnt_val_a;
        vb = cnt_val_b;
    endtask

    function automatic int exp_sel(input int s);
        return (s < 12) ? exp_cnt[s] : 0;
    endfunction

    task automatic test_reset();
        checks++;
        if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 || fifo_count_a !== 3'd0 || fifo_count_b !== 3'd0) begin
            errors++;
            $display("FAIL reset_fifo: rd_valid %b/%b count %0d/%0d, required 0", rd_valid_a, rd_valid_b, fifo_count_a, fifo_count_b);
        end
        checks++;
        if (cnt_val_a !== '0 || overflow_a !== 1'b0 || rd_pc_a !== '0 || rd_inst_a !== '0 || rd_class_a !== '0) begin
            errors++;
            $display("FAIL reset_outputs: cnt_val %0h ovf %b pc %0h inst %0h class %0h, required all 0",
                     cnt_val_a, overflow_a, rd_pc_a, rd_inst_a, rd_class_a);
        end
    endtask

    task automatic test_counters();
        logic [31:0]   insts[6];
        logic [3:0]    cl[6];
        logic [CW-1:0] va, vb;
        insts = '{32'h8C220004, 32'hAC220008, 32'h00221820, 32'h00221822, 32'h10220003, 32'h08000000};
        cl    = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd2, 4'd4};
        trig_en = 1'b0;
        for (int i = 0; i < 6; i++) retire(insts[i], 32'(i * 4), cl[i]);
        for (int s = 0; s < 16; s++) begin
            read_cnt(4'(s), va, vb);
            checks++;
            if (va !== CW'(exp_sel(s)) || vb !== CW'(exp_sel(s))) begin
                errors++;
                $display("FAIL cnt_sel_%0d: got %0d/%0d, required %0d", s, va, vb, exp_sel(s));
            end
        end
        checks++;
        if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL notrig_rd_valid: got %b/%b, required 0", rd_valid_a, rd_valid_b);
        end
    endtask

    task automatic test_fifo_order();
        trig_en  = 1'b1;
        rd_ready = 1'b0;
        retire(32'h8C220004, 32'h0, 4'd0);
        retire(32'hAC220008, 32'h4, 4'd1);
        retire(32'h00221820, 32'h8, 4'd5);
        checks++;
        if (fifo_count_a !== 3'(q0.size()) || fifo_count_b !== 3'(q1.size()) || fifo_count_a !== 3'd3) begin
            errors++;
            $display("FAIL order_count: got %0d/%0d, required 3", fifo_count_a, fifo_count_b);
        end
        rd_ready = 1'b1;
        for (int n = 0; n < 8 && q0.size() != 0; n++) begin
            checks++;
            if (rd_valid_a !== 1'b1 || {rd_pc_a, rd_inst_a, rd_class_a} !== q0[0]) begin
                errors++;
                $display("FAIL order_head: got v=%b pc=%0h inst=%0h cls=%0d, required pc=%0h inst=%0h cls=%0d",
                         rd_valid_a, rd_pc_a, rd_inst_a, rd_class_a, q0[0].pc, q0[0].inst, q0[0].cls);
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++;
        if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 || rd_pc_a !== '0) begin
            errors++;
            $display("FAIL order_empty: rd_valid %b/%b pc %0h, required 0", rd_valid_a, rd_valid_b, rd_pc_a);
        end
    endtask

    task automatic test_overflow();
        trig_en  = 1'b1;
        rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) retire(32'h00221820, 32'(i * 4), 4'd5);
        checks++;
        if (fifo_count_a !== 3'd4 || fifo_count_b !== 3'd4 || overflow_a !== exp_ovf0 || overflow_b !== exp_ovf1 || !exp_ovf0) begin
            errors++;
            $display("FAIL ovf_state: count %0d/%0d ovf %b/%b, required 4/4 ovf 1/1",
                     fifo_count_a, fifo_count_b, overflow_a, overflow_b);
        end
        rd_ready = 1'b1;
        for (int n = 0; n < 8 && q0.size() != 0; n++) begin
            checks++;
            if ({rd_pc_a, rd_inst_a, rd_class_a} !== q0[0] || {rd_pc_b, rd_inst_b, rd_class_b} !== q1[0]) begin
                errors++;
                $display("FAIL ovf_drain: got pc %0h/%0h, required %0h/%0h", rd_pc_a, rd_pc_b, q0[0].pc, q1[0].pc);
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++;
        if (overflow_a !== 1'b1 || overflow_b !== 1'b1 || rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky: ovf %b/%b rd_valid %b/%b, required 1/1 0/0", overflow_a, overflow_b, rd_valid_a, rd_valid_b);
        end
    endtask

    task automatic test_back_to_back();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (overflow_a !== 1'b0 || overflow_b !== 1'b0) begin
            errors++;
            $display("FAIL clr_ovf: got %b/%b, required 0", overflow_a, overflow_b);
        end
        trig_en  = 1'b1;
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) retire(32'h00221822, 32'h100 + 32'(i * 4), 4'd6);
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({rd_pc_a, rd_inst_a, rd_class_a} !== q0[0] || {rd_pc_b, rd_inst_b, rd_class_b} !== q1[0]) begin
                errors++;
                $display("FAIL stream_head_%0d: got pc %0h/%0h, required %0h", i, rd_pc_a, rd_pc_b, q0[0].pc);
            end
            retire(32'h00221824, 32'h200 + 32'(i * 4), 4'd7);
            checks++;
            if (fifo_count_a !== 3'd4 || fifo_count_b !== 3'd4 || overflow_a !== 1'b0 || overflow_b !== 1'b0) begin
                errors++;
                $display("FAIL stream_full_%0d: count %0d/%0d ovf %b/%b, required 4 and 0",
                         i, fifo_count_a, fifo_count_b, overflow_a, overflow_b);
            end
        end
        for (int n = 0; n < 8 && q0.size() != 0; n++) tick();
        rd_ready = 1'b0;
    endtask

    task automatic test_saturation();
        logic [CW-1:0] va, vb;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        trig_en = 1'b0;
        for (int i = 0; i < 20; i++) retire(32'h00221820, 32'(i * 4), 4'd5);
        read_cnt(4'd5, va, vb);
        checks++;
        if (va !== CW'(exp_cnt[5]) || exp_cnt[5] != SAT) begin
            errors++;
            $display("FAIL sat_add: got %0d, required %0d", va, SAT);
        end
        read_cnt(4'd11, va, vb);
        checks++;
        if (va !== CW'(SAT) || vb !== CW'(SAT)) begin
            errors++;
            $display("FAIL sat_total: got %0d/%0d, required %0d", va, vb, SAT);
        end
    endtask

    task automatic test_clr_with_retire();
        logic [CW-1:0] va, vb;
        trig_en  = 1'b1;
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) retire(32'h0022182A, 32'h300 + 32'(i * 4), 4'd9);
        checks++;
        if (overflow_a !== 1'b1 || overflow_b !== 1'b1) begin
            errors++;
            $display("FAIL pre_clr_ovf: got %b/%b, required 1", overflow_a, overflow_b);
        end
        clr       = 1'b1;
        ret_valid = 1'b1;
        ret_inst  = 32'h0022182A;
        ret_pc    = 32'h400;
        cur_cls   = 4'd9;
        tick();
        clr       = 1'b0;
        ret_valid = 1'b0;
        checks++;
        if (fifo_count_a !== 3'd0 || fifo_count_b !== 3'd0 || rd_valid_a !== 1'b0 || overflow_a !== 1'b0 || overflow_b !== 1'b0) begin
            errors++;
            $display("FAIL clr_fifo: count %0d/%0d rd_valid %b ovf %b/%b, required 0",
                     fifo_count_a, fifo_count_b, rd_valid_a, overflow_a, overflow_b);
        end
        for (int s = 0; s < 12; s++) begin
            read_cnt(4'(s), va, vb);
            checks++;
            if (va !== CW'(exp_cnt[s]) || vb !== '0) begin
                errors++;
                $display("FAIL clr_cnt_%0d: got %0d/%0d, required 0", s, va, vb);
            end
        end
    endtask

    task automatic test_other();
        logic [CW-1:0] va, vb;
        trig_en = 1'b0;
        retire(32'h0000000C, 32'h500, 4'd10);
        read_cnt(4'd10, va, vb);
        checks++;
        if (va !== CW'(exp_cnt[10]) || va !== CW'(1)) begin
            errors++;
            $display("FAIL other_cnt: got %0d, required 1", va);
        end
    endtask

    task automatic test_async_reset();
        logic [CW-1:0] va, vb;
        trig_en  = 1'b1;
        rd_ready = 1'b0;
        cnt_sel  = 4'd11;
        for (int i = 0; i < 3; i++) retire(32'h00221825, 32'h600 + 32'(i * 4), 4'd8);
        checks++;
        if (fifo_count_a !== 3'd3 || cnt_val_a === '0) begin
            errors++;
            $display("FAIL pre_rst_state: count %0d cnt_val %0d, required 3 and nonzero", fifo_count_a, cnt_val_a);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rd_valid_a !== 1'b0 || fifo_count_a !== 3'd0 || cnt_val_a !== '0 || rd_pc_a !== '0 || rd_class_a !== '0
            || rd_valid_b !== 1'b0 || fifo_count_b !== 3'd0 || overflow_a !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: rd_valid %b count %0d cnt_val %0d pc %0h, required all 0",
                     rd_valid_a, fifo_count_a, cnt_val_a, rd_pc_a);
        end
        q0.delete();
        q1.delete();
        exp_ovf0 = 1'b0;
        exp_ovf1 = 1'b0;
        for (int i = 0; i < 12; i++) exp_cnt[i] = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        read_cnt(4'd11, va, vb);
        checks++;
        if (va !== CW'(exp_cnt[11]) || vb !== '0) begin
            errors++;
            $display("FAIL post_rst_total: got %0d/%0d, required 0", va, vb);
        end
    endtask

    initial begin
        rst       = 1'b1;
        ret_valid = 1'b0;
        ret_inst  = '0;
        ret_pc    = '0;
        trig_en   = 1'b0;
        clr       = 1'b0;
        cnt_sel   = '0;
        rd_ready  = 1'b0;
        cur_cls   = '0;
        exp_ovf0  = 1'b0;
        exp_ovf1  = 1'b0;
        for (int i = 0; i < 12; i++) exp_cnt[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_counters();
        test_fifo_order();
        test_overflow();
        test_back_to_back();
        test_saturation();
        test_clr_with_retire();
        test_other();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
